// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers.
// Multi-cycle mult/div; mthi/mtlo write in a single cycle.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, q_mag, r_mag, quo, rem;
  logic        sgn;

  // Results are formed only from the operands latched at start.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    sgn    = (op_q == OP_DIV);
    dvd    = (sgn && a_q[31]) ? -a_q : a_q;
    dvs    = (sgn && b_q[31]) ? -b_q : b_q;
    q_mag  = '0;
    r_mag  = '0;
    if (dvs != '0) begin
      q_mag = dvd / dvs;
      r_mag = dvd % dvs;
    end
    quo = (sgn && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem = (sgn && a_q[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT, OP_MULTU: begin
              a_d     = A;
              b_d     = B;
              op_d    = mdop;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = A;
              b_d     = B;
              op_d    = mdop;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT: {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              // Divide by zero leaves HI/LO untouched.
              if (b_q != '0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Expected values are hand-computed constants.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errs;
  int checks;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = 3'b000;
  endtask

  // Counts busy cycles after an issue, sampling on falling edges.
  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 50) begin
        chk("timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  int n;

  initial begin
    errs   = 0;
    checks = 0;
    reset  = 1'b1;
    start  = 1'b1;
    mdop   = 3'b101;
    A      = 32'hFFFF_0000;
    B      = 32'h0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ignore_hi", hi, 32'h0);
    start = 1'b0;
    mdop  = 3'b000;
    @(negedge clk);
    reset = 1'b0;

    issue(3'b010, 32'hFFFF_FFFF, 32'h2);
    wait_done(n);
    chk("multu_cyc", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'b001, 32'hFFFF_FFFD, 32'h7);
    wait_done(n);
    chk("mult_cyc", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(3'b011, 32'hFFFF_FFF9, 32'h2);
    wait_done(n);
    chk("div_cyc", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'b101, 32'h1234_5678, 32'h0);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);

    issue(3'b100, 32'h5, 32'h0);
    wait_done(n);
    chk("div0_cyc", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'hFFFF_FFFD);

    issue(3'b110, 32'h55, 32'h0);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi", hi, 32'h1234_5678);

    // Requests during RUN must be dropped; operands may change freely.
    issue(3'b100, 32'd100, 32'd7);
    n = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      mdop  = 3'b000;
      if (!busy) break;
      n++;
      A = 32'h0BAD_0000 + 32'(n);
      B = 32'h3;
      if (n == 2) begin
        start = 1'b1;
        mdop  = 3'b110;
        A     = 32'hDEAD;
      end
      if (n == 4) begin
        start = 1'b1;
        mdop  = 3'b010;
      end
      if (n == 6) chk("run_hold_lo", lo, 32'h55);
      if (n > 50) break;
    end
    chk("ign_cyc", 32'(n), 32'd10);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    issue(3'b000, 32'h1234, 32'h1);
    issue(3'b111, 32'h1234, 32'h1);
    @(negedge clk);
    mdop = 3'b101;
    A    = 32'h1234;
    @(posedge clk);
    #1;
    mdop = 3'b000;
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_hi", hi, 32'h0);
    chk("nop_lo", lo, 32'h8000_0000);

    // Start coinciding with the completion edge is not taken.
    issue(3'b001, 32'd3, 32'd4);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 5) begin
        start = 1'b1;
        mdop  = 3'b101;
        A     = 32'hAAAA;
      end
      if (n > 50) break;
    end
    chk("edge_cyc", 32'(n), 32'd5);
    chk("edge_hi", hi, 32'h0);
    chk("edge_lo", lo, 32'd12);
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = 3'b000;
    chk("edge_next_hi", hi, 32'hAAAA);

    issue(3'b011, 32'd50, 32'd3);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 3) begin
        reset = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_hi", hi, 32'h0);
        chk("mrst_lo", lo, 32'h0);
        #1;
        reset = 1'b0;
      end
      if (n > 50) break;
    end
    repeat (15) @(posedge clk);
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
